// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a scoreboard that raises the decode stall.
// Define RF_BYPASS_EN to forward same-cycle writeback data and mask operand busy on a matching writeback.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              err_wb
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic wr_live;
  logic busy_a, busy_b, waw;
  logic iss_ok, inc, dec;

  assign wr_live = wr_en && (wr_addr != '0);

`ifdef RF_BYPASS_EN
  logic wr_hit_a, wr_hit_b;
  assign wr_hit_a = wr_live && (wr_addr == rd_addr_a);
  assign wr_hit_b = wr_live && (wr_addr == rd_addr_b);

  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    if (wr_hit_a) rd_data_a = wr_data;
    if (wr_hit_b) rd_data_b = wr_data;
    busy_a = rd_use_a & pend_q[rd_addr_a] & ~wr_hit_a;
    busy_b = rd_use_b & pend_q[rd_addr_b] & ~wr_hit_b;
  end
`else
  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    busy_a    = rd_use_a & pend_q[rd_addr_a];
    busy_b    = rd_use_b & pend_q[rd_addr_b];
  end
`endif

  // A writeback never hides a WAW hazard: the new owner must wait for a clean bit.
  assign waw    = iss_en & pend_q[iss_addr];
  assign stall  = busy_a | busy_b | waw;
  assign iss_ok = iss_en & ~stall;

  // Accepted issues only ever target clear bits, so a same-index writeback cannot decrement.
  assign inc = iss_ok & (iss_addr != '0);
  assign dec = wr_en & pend_q[wr_addr];

  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[wr_addr] = 1'b0;
    if (inc)   pend_d[iss_addr] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    err_d = err_q | (wr_live & ~pend_q[wr_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pend_cnt = cnt_q;
  assign err_wb   = err_q;

endmodule
